// File: rtl/risk_pkg.sv
// Shared risk-control types and defaults.
//   ks_ctrl_state_e : kill-switch supervisor FSM state encoding (3 bits)
//   kill_cause_e    : latched trip cause reported to the host (3 bits)
//   KS_UNLOCK_KEY_DEFAULT / KS_RETRY_CYC_DEFAULT : default parameter values
package risk_pkg;

  typedef enum logic [2:0] {
    KS_DISABLED  = 3'd0,
    KS_MONITOR   = 3'd1,
    KS_TRIPPED   = 3'd2,
    KS_HALTED    = 3'd3,
    KS_UNLOCK    = 3'd4,
    KS_RESETTING = 3'd5
  } ks_ctrl_state_e;

  typedef enum logic [2:0] {
    CAUSE_NONE     = 3'd0,
    CAUSE_HOST     = 3'd1,
    CAUSE_DRAWDOWN = 3'd2,
    CAUSE_WATCHDOG = 3'd3,
    CAUSE_EXTERNAL = 3'd4
  } kill_cause_e;

  localparam logic [31:0] KS_UNLOCK_KEY_DEFAULT = 32'h4B49_4C4C;
  localparam int          KS_RETRY_CYC_DEFAULT  = 8;

endpackage

// File: rtl/drawdown_tracker.sv
// Tracks last P&L, signed running peak and the unsigned drawdown from peak.
//   clk, rst_n     : clock, async active-low reset
//   pnl_valid      : realized_pnl update strobe
//   realized_pnl   : signed two's-complement P&L sample
//   rebase         : move the peak onto the last P&L (drawdown becomes 0)
//   peak_pnl       : registered signed running peak
//   drawdown       : registered peak - last pnl, unsigned, saturating
module drawdown_tracker (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pnl_valid,
  input  logic [63:0] realized_pnl,
  input  logic        rebase,
  output logic [63:0] peak_pnl,
  output logic [63:0] drawdown
);

  logic signed [63:0] peak_q, peak_d;
  logic signed [63:0] last_q, last_d;
  logic signed [63:0] pnl_s;
  logic        [63:0] dd_q, dd_d;
  logic        [64:0] diff;

  assign pnl_s = realized_pnl;

  always_comb begin
    peak_d = peak_q;
    last_d = last_q;
    dd_d   = dd_q;
    diff   = '0;
    if (rebase) begin
      // A sample arriving on the rebase cycle becomes the new baseline.
      last_d = pnl_valid ? pnl_s : last_q;
      peak_d = last_d;
      dd_d   = '0;
    end else if (pnl_valid) begin
      last_d = pnl_s;
      peak_d = (pnl_s > peak_q) ? pnl_s : peak_q;
      // 65-bit difference of sign-extended operands; peak >= pnl keeps it
      // non-negative, the clamp only guards the top bit.
      diff   = {peak_d[63], peak_d} - {pnl_s[63], pnl_s};
      dd_d   = diff[64] ? '1 : diff[63:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_q <= '0;
      last_q <= '0;
      dd_q   <= '0;
    end else begin
      peak_q <= peak_d;
      last_q <= last_d;
      dd_q   <= dd_d;
    end
  end

  assign peak_pnl = peak_q;
  assign drawdown = dd_q;

endmodule

// File: rtl/kill_switch_ctrl.sv
// Supervisory initiator for the order-path kill switch. Watches host kill,
// drawdown and heartbeat watchdog; pulses cmd_trigger until the switch
// confirms, then gates re-enable behind a cooldown and a keyed unlock.
//   clk, rst_n          : clock, async active-low reset
//   cfg_enable          : monitoring enable (only honoured in DISABLED/MONITOR)
//   cfg_hb_timeout      : heartbeat timeout in cycles, 0 disables watchdog
//   cfg_cooldown        : minimum HALTED cycles before unlock is possible
//   cfg_drawdown_limit  : max allowed drawdown (unsigned)
//   host_kill           : software kill pulse
//   host_reset_req      : reset request pulse, sampled with host_unlock_key
//   heartbeat           : strategy liveness pulse
//   pnl_valid           : realized_pnl strobe
//   ks_killed           : kill switch status
//   cmd_trigger/cmd_reset : one-cycle command pulses to the kill switch
//   state, kill_cause, peak_pnl, drawdown, reset_denied, trip_count : status
//
// state        | meaning
// DISABLED  0  | monitoring off
// MONITOR   1  | evaluating trip sources every cycle
// TRIPPED   2  | trigger issued, re-pulsing until ks_killed confirms
// HALTED    3  | kill confirmed, cooldown running
// UNLOCK    4  | waiting for a keyed reset request
// RESETTING 5  | reset issued, re-pulsing until ks_killed drops
module kill_switch_ctrl
  import risk_pkg::*;
#(
  parameter int          CNT_W      = 32,
  parameter logic [31:0] UNLOCK_KEY = KS_UNLOCK_KEY_DEFAULT,
  parameter int          RETRY_CYC  = KS_RETRY_CYC_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_enable,
  input  logic [CNT_W-1:0] cfg_hb_timeout,
  input  logic [CNT_W-1:0] cfg_cooldown,
  input  logic [63:0]      cfg_drawdown_limit,
  input  logic             host_kill,
  input  logic             host_reset_req,
  input  logic [31:0]      host_unlock_key,
  input  logic             heartbeat,
  input  logic             pnl_valid,
  input  logic [63:0]      realized_pnl,
  input  logic             ks_killed,
  output logic             cmd_trigger,
  output logic             cmd_reset,
  output logic [2:0]       state,
  output logic [2:0]       kill_cause,
  output logic [63:0]      peak_pnl,
  output logic [63:0]      drawdown,
  output logic             reset_denied,
  output logic [31:0]      trip_count
);

  localparam int              RT_W    = (RETRY_CYC > 1) ? $clog2(RETRY_CYC) : 1;
  localparam logic [RT_W-1:0] RT_LAST = RT_W'(RETRY_CYC - 1);

  ks_ctrl_state_e   state_q, state_d;
  kill_cause_e      cause_q, cause_d, trip_cause;
  logic [CNT_W-1:0] wd_q, wd_d;
  logic [CNT_W-1:0] cd_q, cd_d;
  logic [RT_W-1:0]  rt_q, rt_d;
  logic             trig_q, trig_d;
  logic             rst_cmd_q, rst_cmd_d;
  logic             denied_q, denied_d;
  logic [31:0]      trips_q, trips_d;
  logic             rebase;
  logic             key_ok, dd_hit, wd_hit, rt_done;

  drawdown_tracker u_dd (
    .clk          (clk),
    .rst_n        (rst_n),
    .pnl_valid    (pnl_valid),
    .realized_pnl (realized_pnl),
    .rebase       (rebase),
    .peak_pnl     (peak_pnl),
    .drawdown     (drawdown)
  );

  assign key_ok  = host_reset_req && (host_unlock_key == UNLOCK_KEY);
  assign dd_hit  = drawdown > cfg_drawdown_limit;
  // A heartbeat on the compare cycle rescues the strategy.
  assign wd_hit  = (cfg_hb_timeout != '0) && (wd_q == cfg_hb_timeout) && !heartbeat;
  assign rt_done = rt_q == RT_LAST;

  always_comb begin
    trip_cause = CAUSE_NONE;
    if (host_kill)      trip_cause = CAUSE_HOST;
    else if (dd_hit)    trip_cause = CAUSE_DRAWDOWN;
    else if (wd_hit)    trip_cause = CAUSE_WATCHDOG;
    else if (ks_killed) trip_cause = CAUSE_EXTERNAL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= KS_DISABLED;
      cause_q   <= CAUSE_NONE;
      wd_q      <= '0;
      cd_q      <= '0;
      rt_q      <= '0;
      trig_q    <= 1'b0;
      rst_cmd_q <= 1'b0;
      denied_q  <= 1'b0;
      trips_q   <= '0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      wd_q      <= wd_d;
      cd_q      <= cd_d;
      rt_q      <= rt_d;
      trig_q    <= trig_d;
      rst_cmd_q <= rst_cmd_d;
      denied_q  <= denied_d;
      trips_q   <= trips_d;
    end
  end

  // Next-state. A trip in MONITOR takes precedence over a disable.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      KS_DISABLED:  if (cfg_enable) state_d = KS_MONITOR;
      KS_MONITOR: begin
        if (trip_cause == CAUSE_EXTERNAL)  state_d = KS_HALTED;
        else if (trip_cause != CAUSE_NONE) state_d = KS_TRIPPED;
        else if (!cfg_enable)              state_d = KS_DISABLED;
      end
      KS_TRIPPED:   if (ks_killed) state_d = KS_HALTED;
      KS_HALTED:    if (cd_q >= cfg_cooldown) state_d = KS_UNLOCK;
      KS_UNLOCK:    if (key_ok) state_d = KS_RESETTING;
      KS_RESETTING: if (!ks_killed) state_d = KS_MONITOR;
      default:      state_d = KS_DISABLED;
    endcase
  end

  // Timers, command pulses and status registers.
  always_comb begin
    wd_d      = wd_q;
    cd_d      = cd_q;
    rt_d      = rt_q;
    trig_d    = 1'b0;
    rst_cmd_d = 1'b0;
    denied_d  = host_reset_req && !((state_q == KS_UNLOCK) && key_ok);
    cause_d   = cause_q;
    trips_d   = trips_q;
    rebase    = 1'b0;
    unique case (state_q)
      KS_DISABLED: wd_d = '0;
      KS_MONITOR: begin
        wd_d = heartbeat ? '0 : wd_q + CNT_W'(1);
        if (trip_cause != CAUSE_NONE) begin
          cause_d = trip_cause;
          trips_d = trips_q + 32'd1;
          rt_d    = '0;
          cd_d    = '0;
          // The switch already reports killed: nothing to trigger.
          trig_d  = (trip_cause != CAUSE_EXTERNAL);
        end
      end
      KS_TRIPPED: begin
        if (ks_killed) begin
          cd_d = '0;
        end else if (rt_done) begin
          trig_d = 1'b1;
          rt_d   = '0;
        end else begin
          rt_d = rt_q + RT_W'(1);
        end
      end
      KS_HALTED: cd_d = cd_q + CNT_W'(1);
      KS_UNLOCK: begin
        if (key_ok) begin
          rst_cmd_d = 1'b1;
          rt_d      = '0;
        end
      end
      KS_RESETTING: begin
        if (!ks_killed) begin
          cause_d = CAUSE_NONE;
          wd_d    = '0;
          rebase  = 1'b1;
        end else if (rt_done) begin
          rst_cmd_d = 1'b1;
          rt_d      = '0;
        end else begin
          rt_d = rt_q + RT_W'(1);
        end
      end
      default: ;
    endcase
  end

  assign cmd_trigger  = trig_q;
  assign cmd_reset    = rst_cmd_q;
  assign state        = state_q;
  assign kill_cause   = cause_q;
  assign reset_denied = denied_q;
  assign trip_count   = trips_q;

endmodule

// File: tb/tb_kill_switch_ctrl.sv
module tb_kill_switch_ctrl;

  localparam logic [31:0] KEY   = 32'h4B49_4C4C;
  localparam int          RETRY = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_enable = 1'b0;
  logic [31:0] cfg_hb_timeout = '0;
  logic [31:0] cfg_cooldown = '0;
  logic [63:0] cfg_drawdown_limit = '1;
  logic        host_kill = 1'b0;
  logic        host_reset_req = 1'b0;
  logic [31:0] host_unlock_key = '0;
  logic        heartbeat = 1'b0;
  logic        pnl_valid = 1'b0;
  logic [63:0] realized_pnl = '0;
  logic        ks_killed = 1'b0;
  logic        cmd_trigger, cmd_reset, reset_denied;
  logic [2:0]  state, kill_cause;
  logic [63:0] peak_pnl, drawdown;
  logic [31:0] trip_count;

  always #5 clk = ~clk;

  kill_switch_ctrl #(.CNT_W(32), .UNLOCK_KEY(KEY), .RETRY_CYC(RETRY)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_enable(cfg_enable), .cfg_hb_timeout(cfg_hb_timeout),
    .cfg_cooldown(cfg_cooldown), .cfg_drawdown_limit(cfg_drawdown_limit),
    .host_kill(host_kill), .host_reset_req(host_reset_req), .host_unlock_key(host_unlock_key),
    .heartbeat(heartbeat), .pnl_valid(pnl_valid), .realized_pnl(realized_pnl),
    .ks_killed(ks_killed), .cmd_trigger(cmd_trigger), .cmd_reset(cmd_reset),
    .state(state), .kill_cause(kill_cause), .peak_pnl(peak_pnl), .drawdown(drawdown),
    .reset_denied(reset_denied), .trip_count(trip_count)
  );

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got 0x%0h want 0x%0h", name, $time, act, exp);
    end
  endtask

  // Behavioural reference: states as plain integers, ages as cycle counts.
  int                 m_state, m_cause;
  longint             m_hb_age, m_halt_age, m_since;
  logic [31:0]        m_trips;
  logic signed [63:0] m_peak, m_last;
  logic signed [64:0] m_diff;
  logic [63:0]        m_dd;
  logic               m_trig, m_rst, m_denied;

  task automatic model_step();
    bit key_ok, rebase;
    int cause;
    if (!rst_n) begin
      m_state = 0; m_cause = 0; m_trips = '0; m_peak = '0; m_last = '0; m_dd = '0;
      m_trig = 0; m_rst = 0; m_denied = 0; m_hb_age = 0; m_halt_age = 0; m_since = 0;
      return;
    end
    key_ok   = host_reset_req && (host_unlock_key == KEY);
    rebase   = 0;
    m_trig   = 0;
    m_rst    = 0;
    m_denied = host_reset_req && !(m_state == 4 && key_ok);
    case (m_state)
      0: if (cfg_enable) begin m_state = 1; m_hb_age = 0; end
      1: begin
        if (host_kill) cause = 1;
        else if (m_dd > cfg_drawdown_limit) cause = 2;
        else if (cfg_hb_timeout != 0 && m_hb_age == longint'(cfg_hb_timeout) && !heartbeat) cause = 3;
        else if (ks_killed) cause = 4;
        else cause = 0;
        m_hb_age = heartbeat ? 0 : m_hb_age + 1;
        if (cause != 0) begin
          m_cause = cause;
          m_trips = m_trips + 1;
          if (cause == 4) begin m_state = 3; m_halt_age = 0; end
          else begin m_state = 2; m_trig = 1; m_since = 0; end
        end else if (!cfg_enable) m_state = 0;
      end
      2: begin
        if (ks_killed) begin m_state = 3; m_halt_age = 0; end
        else begin
          m_since = m_since + 1;
          if (m_since == RETRY) begin m_trig = 1; m_since = 0; end
        end
      end
      3: begin
        if (m_halt_age >= longint'(cfg_cooldown)) m_state = 4;
        else m_halt_age = m_halt_age + 1;
      end
      4: if (key_ok) begin m_state = 5; m_rst = 1; m_since = 0; end
      5: begin
        if (!ks_killed) begin m_state = 1; m_cause = 0; m_hb_age = 0; rebase = 1; end
        else begin
          m_since = m_since + 1;
          if (m_since == RETRY) begin m_rst = 1; m_since = 0; end
        end
      end
      default: m_state = 0;
    endcase
    if (rebase) begin
      if (pnl_valid) m_last = realized_pnl;
      m_peak = m_last;
      m_dd   = '0;
    end else if (pnl_valid) begin
      m_last = realized_pnl;
      if (m_last > m_peak) m_peak = m_last;
      m_diff = 65'(m_peak) - 65'(m_last);
      m_dd   = (m_diff > 65'sh0_FFFF_FFFF_FFFF_FFFF) ? 64'hFFFF_FFFF_FFFF_FFFF : m_diff[63:0];
    end
  endtask

  always @(posedge clk or negedge rst_n) model_step();

  logic prev_trig = 1'b0, prev_rst = 1'b0;

  task automatic compare_all();
    chk("state", 64'(state), 64'(m_state));
    chk("kill_cause", 64'(kill_cause), 64'(m_cause));
    chk("trip_count", 64'(trip_count), 64'(m_trips));
    chk("cmd_trigger", 64'(cmd_trigger), 64'(m_trig));
    chk("cmd_reset", 64'(cmd_reset), 64'(m_rst));
    chk("reset_denied", 64'(reset_denied), 64'(m_denied));
    chk("peak_pnl", peak_pnl, m_peak);
    chk("drawdown", drawdown, m_dd);
    chk("cmd_exclusive", 64'(cmd_trigger & cmd_reset), 64'(0));
    chk("cmd_single_cycle", 64'((cmd_trigger & prev_trig) | (cmd_reset & prev_rst)), 64'(0));
    prev_trig = cmd_trigger;
    prev_rst  = cmd_reset;
  endtask

  always @(negedge clk) if (chk_en && rst_n) compare_all();

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_state(input int target, input int budget, input string name);
    int k = 0;
    while (int'(state) != target && k < budget) begin tick(); k++; end
    chk(name, 64'(state), 64'(target));
  endtask

  task automatic recover();
    ks_killed = 1'b1;
    wait_state(4, 2000, "rec_unlock");
    host_unlock_key = KEY; host_reset_req = 1'b1; tick(); host_reset_req = 1'b0;
    ks_killed = 1'b0;
    wait_state(1, 100, "rec_monitor");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [31:0] mask;
    cfg_cooldown = 32'd50;
    tick(2);
    chk("rst_state", 64'(state), 64'(0));
    chk("rst_trig", 64'(cmd_trigger), 64'(0));
    chk("rst_cmd_reset", 64'(cmd_reset), 64'(0));
    chk("rst_cause", 64'(kill_cause), 64'(0));
    chk("rst_peak", peak_pnl, 64'(0));
    chk("rst_dd", drawdown, 64'(0));
    chk("rst_trips", 64'(trip_count), 64'(0));
    chk("rst_denied", 64'(reset_denied), 64'(0));
    #2 rst_n = 1'b1;
    tick();
    chk_en = 1'b1;

    // host kill: trigger one cycle after the request, HALTED after confirm
    cfg_enable = 1'b1; tick();
    chk("en_monitor", 64'(state), 64'(1));
    host_kill = 1'b1; tick(); host_kill = 1'b0;
    chk("hk_trig", 64'(cmd_trigger), 64'(1));
    chk("hk_state", 64'(state), 64'(2));
    chk("hk_cause", 64'(kill_cause), 64'(1));
    chk("hk_trips", 64'(trip_count), 64'(1));
    tick();
    chk("hk_trig_once", 64'(cmd_trigger), 64'(0));
    tick(); ks_killed = 1'b1; tick();
    chk("hk_halted", 64'(state), 64'(3));

    // cooldown and keyed unlock
    tick(10);
    host_unlock_key = KEY; host_reset_req = 1'b1; tick(); host_reset_req = 1'b0;
    chk("early_denied", 64'(reset_denied), 64'(1));
    chk("early_state", 64'(state), 64'(3));
    n = 11;
    while (state != 3'd4 && n < 200) begin tick(); n++; end
    chk("cooldown_len", 64'(n), 64'(51));
    host_unlock_key = 32'h1234_5678; host_reset_req = 1'b1; tick(); host_reset_req = 1'b0;
    chk("wrongkey_denied", 64'(reset_denied), 64'(1));
    chk("wrongkey_state", 64'(state), 64'(4));
    host_unlock_key = KEY; host_reset_req = 1'b1; tick(); host_reset_req = 1'b0;
    chk("key_cmd_reset", 64'(cmd_reset), 64'(1));
    chk("key_state", 64'(state), 64'(5));
    ks_killed = 1'b0; tick();
    chk("rel_state", 64'(state), 64'(1));
    chk("rel_cause", 64'(kill_cause), 64'(0));
    chk("rel_dd", drawdown, 64'(0));

    // drawdown: strictly greater than the limit trips
    cfg_drawdown_limit = 64'd1000; cfg_cooldown = '0;
    pnl_valid = 1'b1; realized_pnl = 64'd5000; tick();
    realized_pnl = 64'd3999; tick(); pnl_valid = 1'b0;
    chk("dd_peak", peak_pnl, 64'd5000);
    chk("dd_value", drawdown, 64'd1001);
    tick();
    chk("dd_trig", 64'(cmd_trigger), 64'(1));
    chk("dd_cause", 64'(kill_cause), 64'(2));
    recover();
    chk("rebase_dd", drawdown, 64'(0));
    chk("rebase_peak", peak_pnl, 64'd3999);
    pnl_valid = 1'b1; realized_pnl = 64'd5000; tick();
    realized_pnl = 64'd4000; tick(); pnl_valid = 1'b0;
    chk("dd_at_limit", drawdown, 64'd1000);
    tick(3);
    chk("dd_at_limit_no_trip", 64'(state), 64'(1));

    // watchdog
    tick(40);
    chk("wd_disabled", 64'(state), 64'(1));
    heartbeat = 1'b1; cfg_hb_timeout = 32'd20; tick(); heartbeat = 1'b0;
    tick(20);
    chk("wd_pre_trip", 64'(state), 64'(1));
    tick();
    chk("wd_trig", 64'(cmd_trigger), 64'(1));
    chk("wd_cause", 64'(kill_cause), 64'(3));

    // retry while unconfirmed
    mask = '0;
    for (int k = 1; k <= 17; k++) begin
      tick();
      if (cmd_trigger) mask[k] = 1'b1;
    end
    chk("retry_pulses", 64'(mask), 64'(32'h0001_0100));
    ks_killed = 1'b1; tick();
    chk("retry_halted", 64'(state), 64'(3));
    recover();

    // heartbeat on the compare cycle wins
    tick(20);
    heartbeat = 1'b1; tick(); heartbeat = 1'b0;
    chk("wd_hb_wins", 64'(state), 64'(1));
    chk("wd_hb_no_trig", 64'(cmd_trigger), 64'(0));
    cfg_hb_timeout = '0;

    // priority: host kill beats a coincident drawdown breach
    pnl_valid = 1'b1; realized_pnl = 64'd5000; tick();
    realized_pnl = 64'd3000; tick(); pnl_valid = 1'b0;
    host_kill = 1'b1; tick(); host_kill = 1'b0;
    chk("prio_cause", 64'(kill_cause), 64'(1));
    chk("prio_trig", 64'(cmd_trigger), 64'(1));
    chk("prio_trips", 64'(trip_count), 64'(4));
    tick();
    chk("prio_single", 64'(cmd_trigger), 64'(0));
    recover();

    // external trip, then disable does not release
    cfg_cooldown = 32'd1000;
    ks_killed = 1'b1; tick();
    chk("ext_state", 64'(state), 64'(3));
    chk("ext_cause", 64'(kill_cause), 64'(4));
    chk("ext_no_trig", 64'(cmd_trigger), 64'(0));
    chk("ext_trips", 64'(trip_count), 64'(5));
    cfg_enable = 1'b0; tick(3);
    chk("disable_ignored", 64'(state), 64'(3));
    cfg_enable = 1'b1; cfg_cooldown = '0;
    recover();

    // extreme P&L swing: full-range drawdown
    cfg_drawdown_limit = '1;
    pnl_valid = 1'b1; realized_pnl = 64'h7FFF_FFFF_FFFF_FFFF; tick();
    realized_pnl = 64'h8000_0000_0000_0000; tick(); pnl_valid = 1'b0;
    chk("ext_peak", peak_pnl, 64'h7FFF_FFFF_FFFF_FFFF);
    chk("ext_dd", drawdown, 64'hFFFF_FFFF_FFFF_FFFF);

    // randomized run against the model
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) begin
        cfg_hb_timeout     = $urandom_range(0, 25);
        cfg_cooldown       = $urandom_range(0, 12);
        cfg_drawdown_limit = 64'($urandom_range(300, 3000));
        cfg_enable         = ($urandom_range(0, 5) != 0);
      end
      host_kill       = ($urandom_range(0, 39) == 0);
      host_reset_req  = ($urandom_range(0, 7) == 0);
      host_unlock_key = ($urandom_range(0, 1) == 1) ? KEY : $urandom;
      heartbeat       = ($urandom_range(0, 14) == 0);
      pnl_valid       = ($urandom_range(0, 3) == 0);
      realized_pnl    = 64'(longint'($urandom_range(0, 4000)) - longint'(2000));
      if ($urandom_range(0, 9) == 0) ks_killed = ~ks_killed;
      if (c == 2000) begin
        #2 rst_n = 1'b0;
        tick();
        chk("midrst_state", 64'(state), 64'(0));
        chk("midrst_trig", 64'(cmd_trigger | cmd_reset), 64'(0));
        #2 rst_n = 1'b1;
      end else begin
        tick();
      end
    end
    host_kill = 1'b0; host_reset_req = 1'b0; pnl_valid = 1'b0; heartbeat = 1'b0;
    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/kill_switch_ctrl.md
Name: kill_switch_ctrl

Overview:
- Supervisory initiator that drives the `cmd_trigger` / `cmd_reset` pulse interface of the order-path kill switch.
- Monitors three trip sources: host kill requests, P&L drawdown from running peak, and a strategy heartbeat watchdog.
- Issues trigger pulses, retrying until the kill switch confirms via its `killed` status; confirmation is required for the kill to take effect.
- Re-enable is gated by a cooldown plus a keyed unlock, so a release always takes a deliberate two-step host action.

Parameters:
- CNT_W, 32, width of watchdog and cooldown counters/configs
- UNLOCK_KEY, 32'h4B49_4C4C, key value required with a reset request
- RETRY_CYC, 8, cycles between command re-pulses while awaiting confirmation

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cfg_enable  in  1  monitoring enable
- cfg_hb_timeout  in  CNT_W  heartbeat timeout in cycles; 0 disables watchdog
- cfg_cooldown  in  CNT_W  minimum cycles in HALTED before unlock is accepted
- cfg_drawdown_limit  in  64  max allowed drawdown (unsigned)
- host_kill  in  1  software kill pulse
- host_reset_req  in  1  reset request pulse
- host_unlock_key  in  32  key sampled with host_reset_req
- heartbeat  in  1  strategy liveness pulse
- pnl_valid  in  1  realized_pnl update strobe
- realized_pnl  in  64  signed two's-complement P&L
- ks_killed  in  1  kill switch `killed` status
- cmd_trigger  out  1  trigger pulse to kill switch
- cmd_reset  out  1  reset pulse to kill switch
- state  out  3  current FSM state
- kill_cause  out  3  latched cause: 0 none, 1 host, 2 drawdown, 3 watchdog, 4 external
- peak_pnl  out  64  signed running peak
- drawdown  out  64  peak_pnl − last pnl, unsigned
- reset_denied  out  1  one-cycle pulse on rejected reset request
- trip_count  out  32  number of MONITOR→trip exits

Behaviour:

Reset values:
- All outputs 0; state = DISABLED.
- peak_pnl = 0, last pnl = 0; all counters 0.

FSM states: DISABLED(0), MONITOR(1), TRIPPED(2), HALTED(3), UNLOCK(4), RESETTING(5).
- **DISABLED → MONITOR:** when cfg_enable = 1; watchdog counter cleared.
- **MONITOR → DISABLED:** when cfg_enable = 0. cfg_enable is ignored in states 2–5, so a disable never releases an active kill.

MONITOR trip check, evaluated every cycle. Priority when sources coincide:
- host_kill > drawdown > watchdog > external.
- The highest-priority source is latched into kill_cause.

Trip sources:
- drawdown: registered `drawdown > cfg_drawdown_limit`, strictly greater.
- watchdog: cfg_hb_timeout ≠ 0 and counter == cfg_hb_timeout.
  - Counter increments each MONITOR cycle and clears on heartbeat.
  - heartbeat in the same cycle as the compare wins, i.e. no trip.
- external: ks_killed = 1 while in MONITOR.
  - Goes directly to HALTED; no cmd_trigger is issued.

Host trip, drawdown trip or watchdog trip:
- Go to TRIPPED.
- Increment trip_count.
- Pulse cmd_trigger for one cycle.
- Trip cmd_trigger is registered: asserted the cycle after the condition is sampled.

External trip:
- Goes to HALTED.
- trip_count also increments.

TRIPPED:
- Re-pulse cmd_trigger every RETRY_CYC cycles until ks_killed = 1 is sampled.
- Then go to HALTED; cooldown counter cleared.

HALTED:
- Cooldown counter increments.
- When counter ≥ cfg_cooldown (cfg_cooldown = 0 means immediately next cycle), go to UNLOCK.

UNLOCK:
- host_reset_req with host_unlock_key == UNLOCK_KEY → RESETTING; cmd_reset pulses the next cycle.
- A wrong key keeps the state unchanged.

RESETTING:
- Re-pulse cmd_reset every RETRY_CYC cycles until ks_killed = 0 is sampled.
- Then go to MONITOR, with these clears:
  - kill_cause = 0
  - watchdog cleared
  - peak_pnl rebased to last pnl, so drawdown = 0

Rejected reset requests:
- reset_denied pulses one cycle after any host_reset_req that is rejected: outside UNLOCK, or with a wrong key in UNLOCK.

cmd_trigger and cmd_reset:
- Never asserted in the same cycle.
- Never asserted for more than 1 consecutive cycle.

host_kill outside MONITOR: ignored; no second trigger, no count.

P&L tracking, on pnl_valid in any state:
- last pnl <= realized_pnl.
- peak_pnl <= max(peak_pnl, realized_pnl), signed compare.
- drawdown <= peak − pnl, computed in 65 bits and saturated to 2^64−1.
- Drawdown is registered: a trip is seen 1 cycle after the pnl_valid that raises drawdown above limit.

Async reset mid-operation returns to DISABLED with no command pulses. Downstream kill switch state is not touched.

Decomposition:
- risk_pkg additions:
  - `ks_ctrl_state_e` (3-bit enum)
  - `kill_cause_e` (3-bit enum)
  - `KS_UNLOCK_KEY_DEFAULT`
  - `KS_RETRY_CYC_DEFAULT`
- Sub-module drawdown_tracker (pnl_valid/realized_pnl in; peak_pnl, drawdown, rebase input out) holds the signed peak and saturating subtraction.
- FSM, watchdog, cooldown and retry timers stay in kill_switch_ctrl.

Test Plan:
- **Host kill:** enable, host_kill at cycle 10 → cmd_trigger = 1 at cycle 11 only, kill_cause = 1, trip_count = 1; ks_killed = 1 at cycle 13 → state HALTED at cycle 14.
- **Drawdown:** limit = 1000; pnl 5000 then 3999 → peak 5000, drawdown 1001, cmd_trigger, cause 2. pnl 4000 instead → drawdown 1000, no trip.
- **Watchdog:** timeout = 20, no heartbeat → trip at count 20, cause 3. Heartbeat on the compare cycle → no trip. Timeout = 0 → never trips.
- **Retry:** hold ks_killed = 0 in TRIPPED → cmd_trigger pulses every 8 cycles. Assert ks_killed → pulses stop, HALTED.
- **Reset gating:** cooldown = 50. reset_req with correct key at cooldown cycle 10 → reset_denied. Wrong key in UNLOCK → reset_denied, state stays. Correct key → cmd_reset next cycle; ks_killed = 0 → MONITOR, drawdown = 0, cause = 0.
- **Priority / external / disable:** host_kill and drawdown breach same cycle → cause 1, single cmd_trigger. ks_killed rising in MONITOR → HALTED, cause 4, no cmd_trigger. cfg_enable = 0 while HALTED → state unchanged.
